alu_ctrl_seq: RTL and testbench

Registered, multi-cycle successor to the combinational ALU control decoder. It sits between instruction decode and the datapath ALU. It accepts one decoded operation per valid/ready handshake and drives the ALU control lines from registers. Shifts are sequenced as one single-bit step per cycle for a programmable count, and a carry flag is kept for ADDC/SUBC.

---
 rtl/alu_ctrl_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// ----------------------------------------------------------------------------
// alu_ctrl_seq
// Registered, multi-cycle ALU control sequencer. Accepts one decoded operation
// per valid/ready handshake, drives the ALU control lines from registers, and
// sequences shifts as one single-bit step per cycle for a programmable count.
//
// Optional feature macro: ALU_CTRL_SEQ_CARRY_EN
//   defined   : CarryFlag captures alu_cout on the Done cycle of
//               ADD/ADDC/SUB/SUBC/CMP; ADDC/SUBC use the stored CarryFlag as Cin.
//   undefined : CarryFlag is tied to 0, Cin = Sub, alu_cout is ignored.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operation handshake (in_ready high only in IDLE)
//   ALUop                 00 RTYP, 01 ITYP, 10 SHFT, 11 reserved
//   OPCode                primary opcode (decoded for ITYP)
//   OPCodeExtension       extension field (decoded for RTYP and SHFT)
//   ShAmtImm, ShAmtReg    immediate / register-sourced shift counts
//   alu_cout              ALU carry-out, sampled on the Done cycle only
//   out_valid             controls are meaningful this cycle
//   ALUcontrol, Ainv, Binv, Sub, ShiftImm, Cin   registered ALU controls
//   Step                  perform a one-bit shift this cycle
//   Done                  last cycle of the operation
//   CarryFlag             stored carry
// ----------------------------------------------------------------------------
module alu_ctrl_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     ALUop,
    input  logic [3:0]     OPCode,
    input  logic [3:0]     OPCodeExtension,
    input  logic [SHW-1:0] ShAmtImm,
    input  logic [SHW-1:0] ShAmtReg,
    input  logic           alu_cout,
    output logic           out_valid,
    output logic [2:0]     ALUcontrol,
    output logic           Ainv,
    output logic           Binv,
    output logic           Sub,
    output logic           ShiftImm,
    output logic           Cin,
    output logic           Step,
    output logic           Done,
    output logic           CarryFlag
);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;

    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_ADDU = 4'b0110;
    localparam logic [3:0] OP_ADDC = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_SUBC = 4'b1010;
    localparam logic [3:0] OP_CMP  = 4'b1011;

    localparam logic [SHW-1:0] MAX_CNT = SHW'(WIDTH);

    state_t         state;
    logic [SHW-1:0] count;

    // Decode of the operation currently offered on the inputs.
    logic           arith;
    logic [3:0]     code;
    logic [2:0]     d_ctrl;
    logic           d_binv, d_sub, d_shimm, d_shift, d_cin;
    logic [SHW-1:0] d_amt, d_cnt;
    logic           accept;

    assign accept = in_valid && in_ready;
    assign arith  = (ALUop == 2'b00) || (ALUop == 2'b01);
    assign code   = (ALUop == 2'b00) ? OPCodeExtension : OPCode;

    always_comb begin
        // NOTE: every decode output gets a default before the case so no path
        // leaves a variable unassigned, which would infer a latch.
        d_ctrl  = 3'b000;
        d_binv  = 1'b0;
        d_sub   = 1'b0;
        d_shimm = 1'b0;
        d_shift = 1'b0;
        d_amt   = '0;
        if (arith) begin
            unique case (code)
                OP_AND:                 d_ctrl = 3'b001;
                OP_OR:                  d_ctrl = 3'b010;
                OP_XOR:                 d_ctrl = 3'b011;
                OP_SUB, OP_SUBC, OP_CMP: begin
                    d_binv = 1'b1;
                    d_sub  = 1'b1;
                end
                default:                d_ctrl = 3'b000;
            endcase
        end else if (ALUop == 2'b10) begin
            unique case (OPCodeExtension)
                4'b0100, 4'b0110: begin
                    d_ctrl  = 3'b101;
                    d_shift = 1'b1;
                    d_amt   = ShAmtReg;
                end
                4'b0000, 4'b0010: begin
                    d_ctrl  = 3'b101;
                    d_shimm = 1'b1;
                    d_shift = 1'b1;
                    d_amt   = ShAmtImm;
                end
                4'b0001: begin
                    d_ctrl  = 3'b111;
                    d_shimm = 1'b1;
                    d_shift = 1'b1;
                    d_amt   = ShAmtImm;
                end
                4'b0011: begin
                    d_ctrl  = 3'b110;
                    d_shimm = 1'b1;
                    d_shift = 1'b1;
                    d_amt   = ShAmtImm;
                end
                default: d_ctrl = 3'b000;   // unknown shift: plain one-cycle op
            endcase
        end
        // Counts at or beyond the datapath width saturate at WIDTH steps.
        d_cnt = (d_amt >= MAX_CNT) ? MAX_CNT : d_amt;
    end

`ifdef ALU_CTRL_SEQ_CARRY_EN
    logic d_upd, d_usecf, upd_q, carry_q;

    assign d_upd  = arith && (code inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP});
    assign d_usecf = arith && (code inside {OP_ADDC, OP_SUBC});
    // Carry-chained ops take the stored flag, not this operation's own result.
    assign d_cin     = d_usecf ? carry_q : d_sub;
    assign CarryFlag = carry_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
            upd_q   <= 1'b0;
        end else if (state == IDLE && accept) begin
            upd_q <= d_upd;
        end else if (Done && upd_q) begin
            carry_q <= alu_cout;
        end
    end
`else
    logic unused_alu_cout;

    assign unused_alu_cout = alu_cout;
    assign d_cin           = d_sub;
    assign CarryFlag       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            ALUcontrol <= 3'b000;
            Ainv       <= 1'b0;
            Binv       <= 1'b0;
            Sub        <= 1'b0;
            ShiftImm   <= 1'b0;
            Cin        <= 1'b0;
            Step       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        in_ready   <= 1'b0;
                        out_valid  <= 1'b1;
                        ALUcontrol <= d_ctrl;
                        Ainv       <= 1'b0;
                        Binv       <= d_binv;
                        Sub        <= d_sub;
                        ShiftImm   <= d_shimm;
                        Cin        <= d_cin;
                        if (d_shift && d_cnt != '0) begin
                            state <= SHIFT;
                            count <= d_cnt;
                            Step  <= 1'b1;
                            Done  <= (d_cnt == SHW'(1));
                        end else begin
                            state <= EXEC;
                            count <= '0;
                            Step  <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end
                end
                EXEC, SHIFT: begin
                    if (Done) begin
                        state      <= IDLE;
                        count      <= '0;
                        in_ready   <= 1'b1;
                        out_valid  <= 1'b0;
                        ALUcontrol <= 3'b000;
                        Binv       <= 1'b0;
                        Sub        <= 1'b0;
                        ShiftImm   <= 1'b0;
                        Cin        <= 1'b0;
                        Step       <= 1'b0;
                        Done       <= 1'b0;
                    end else begin
                        // Only SHIFT gets here; controls stay frozen.
                        count <= count - SHW'(1);
                        Done  <= (count == SHW'(2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_ctrl_seq
// Self-checking bench for alu_ctrl_seq: directed steps from the test plan
// followed by randomized operations, compared against a behavioural model of
// the decode rules, cycle counts and the carry flag.
// ----------------------------------------------------------------------------
module tb_alu_ctrl_seq;

    localparam int WIDTH = 16;
    localparam int SHW   = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     ALUop;
    logic [3:0]     OPCode;
    logic [3:0]     OPCodeExtension;
    logic [SHW-1:0] ShAmtImm;
    logic [SHW-1:0] ShAmtReg;
    logic           alu_cout;
    logic           out_valid;
    logic [2:0]     ALUcontrol;
    logic           Ainv, Binv, Sub, ShiftImm, Cin, Step, Done, CarryFlag;

    int   checks   = 0;
    int   errors   = 0;
    logic model_cf = 1'b0;

    alu_ctrl_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .ALUop           (ALUop),
        .OPCode          (OPCode),
        .OPCodeExtension (OPCodeExtension),
        .ShAmtImm        (ShAmtImm),
        .ShAmtReg        (ShAmtReg),
        .alu_cout        (alu_cout),
        .out_valid       (out_valid),
        .ALUcontrol      (ALUcontrol),
        .Ainv            (Ainv),
        .Binv            (Binv),
        .Sub             (Sub),
        .ShiftImm        (ShiftImm),
        .Cin             (Cin),
        .Step            (Step),
        .Done            (Done),
        .CarryFlag       (CarryFlag)
    );

    always #5 clk = ~clk;

    // Expected behaviour of one operation, derived from the decode rules.
    typedef struct {
        logic [2:0] ctrl;
        logic       binv, sub, shimm, cin, step, upd;
        int         cycles;
    } exp_t;

    function automatic exp_t model_op(input logic [1:0] op, input logic [3:0] opc,
                                      input logic [3:0] ext, input int imm,
                                      input int rg, input logic cf);
        exp_t       e;
        logic [3:0] c;
        int         n;
        e.ctrl = 3'd0; e.binv = 1'b0; e.sub = 1'b0; e.shimm = 1'b0;
        e.cin = 1'b0; e.step = 1'b0; e.upd = 1'b0; e.cycles = 1;
        if (op == 2'b10) begin
            n = -1;
            if (ext == 4'd4 || ext == 4'd6)      begin e.ctrl = 3'd5; n = rg; end
            else if (ext == 4'd0 || ext == 4'd2) begin e.ctrl = 3'd5; e.shimm = 1'b1; n = imm; end
            else if (ext == 4'd1)                begin e.ctrl = 3'd7; e.shimm = 1'b1; n = imm; end
            else if (ext == 4'd3)                begin e.ctrl = 3'd6; e.shimm = 1'b1; n = imm; end
            if (n >= 0) begin
                if (n > WIDTH) n = WIDTH;
                e.step   = (n > 0);
                e.cycles = (n > 0) ? n : 1;
            end
        end else if (op != 2'b11) begin
            c = (op == 2'b00) ? ext : opc;
            if (c == 4'd1) e.ctrl = 3'd1;
            if (c == 4'd2) e.ctrl = 3'd2;
            if (c == 4'd3) e.ctrl = 3'd3;
            if (c == 4'd9 || c == 4'd10 || c == 4'd11) begin
                e.binv = 1'b1;
                e.sub  = 1'b1;
            end
            e.cin = e.sub;
`ifdef ALU_CTRL_SEQ_CARRY_EN
            e.upd = (c == 4'd5 || c == 4'd7 || c == 4'd9 || c == 4'd10 || c == 4'd11);
            if (c == 4'd7 || c == 4'd10) e.cin = cf;
`endif
        end
        return e;
    endfunction

    function automatic logic [12:0] observed();
        return {out_valid, ALUcontrol, Ainv, Binv, Sub, ShiftImm, Cin, Step, Done,
                in_ready, CarryFlag};
    endfunction

    function automatic logic [12:0] expect_vec(input logic v, input logic [2:0] ctrl,
                                               input logic binv, input logic sub,
                                               input logic shimm, input logic cin,
                                               input logic step, input logic done,
                                               input logic rdy, input logic cf);
        return {v, ctrl, 1'b0, binv, sub, shimm, cin, step, done, rdy, cf};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one operation at a falling edge and follow it to completion.
    // cout_sel < 0 drives random alu_cout, otherwise its LSB.
    task automatic run_op(input logic [1:0] op, input logic [3:0] opc, input logic [3:0] ext,
                          input int imm, input int rg, input int cout_sel, input string tag);
        exp_t e;
        logic done;
        e = model_op(op, opc, ext, imm, rg, model_cf);
        check({tag, " ready"}, 32'(in_ready), 32'd1);
        ALUop = op; OPCode = opc; OPCodeExtension = ext;
        ShAmtImm = SHW'(imm); ShAmtReg = SHW'(rg);
        in_valid = 1'b1;
        @(negedge clk);
        // Scramble inputs to confirm everything was latched at the transfer.
        in_valid = 1'b0;
        ALUop = 2'($urandom); OPCode = 4'($urandom); OPCodeExtension = 4'($urandom);
        ShAmtImm = SHW'($urandom); ShAmtReg = SHW'($urandom);
        for (int i = 0; i < e.cycles; i++) begin
            done = (i == e.cycles - 1);
            check({tag, " cycle"}, 32'(observed()),
                  32'(expect_vec(1'b1, e.ctrl, e.binv, e.sub, e.shimm, e.cin, e.step,
                                 done, 1'b0, model_cf)));
            alu_cout = (cout_sel < 0) ? 1'($urandom) : cout_sel[0];
            if (done && e.upd) model_cf = alu_cout;
            @(negedge clk);
        end
        check({tag, " after"}, 32'(observed()),
              32'(expect_vec(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, model_cf)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] rop;
        logic [12:0] zero_vec;
        zero_vec = '0;

        // Reset with an operation offered: nothing accepted, all outputs 0.
        reset = 1'b1; in_valid = 1'b1; ALUop = 2'b00; OPCode = 4'd0;
        OPCodeExtension = 4'd5; ShAmtImm = '0; ShAmtReg = '0; alu_cout = 1'b1;
        @(negedge clk);
        check("reset outputs", 32'(observed()), 32'(zero_vec));
        @(negedge clk);
        check("reset with in_valid", 32'(observed()), 32'(zero_vec));
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("ready after release", 32'(observed()),
              32'(expect_vec(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle out_valid", 32'(out_valid), 32'd0);
        end

        // Directed operations.
        run_op(2'b01, 4'b1001, 4'd0, 0, 0, -1, "itype sub");
        run_op(2'b00, 4'd0, 4'b0011, 0, 0, -1, "rtype xor");
        run_op(2'b01, 4'b0001, 4'd0, 0, 0, -1, "itype and");
        run_op(2'b10, 4'd0, 4'b0001, 5, 0, -1, "shift imm 5");
        run_op(2'b10, 4'd0, 4'b0001, 20, 0, -1, "shift imm 20");
        run_op(2'b10, 4'd0, 4'b0001, 0, 0, -1, "shift imm 0");
        run_op(2'b10, 4'd0, 4'b0100, 3, 31, -1, "shift reg 31");
        run_op(2'b10, 4'd0, 4'b0011, 16, 0, -1, "shift imm 16");
        run_op(2'b10, 4'd0, 4'b1111, 7, 7, -1, "shift unknown");
        run_op(2'b11, 4'b1001, 4'b1001, 0, 0, -1, "reserved aluop");

        // Carry chain: ADD sets the flag, ADDU keeps it, ADDC consumes it.
        run_op(2'b00, 4'd0, 4'b0101, 0, 0, 1, "add cout1");
        run_op(2'b00, 4'd0, 4'b0110, 0, 0, 0, "addu cout0");
        check("carry after addu", 32'(CarryFlag), 32'(model_cf));
        run_op(2'b00, 4'd0, 4'b0111, 0, 0, 0, "addc");
        run_op(2'b01, 4'b1010, 4'd0, 0, 0, 1, "itype subc");

        // Reset on the 3rd cycle of an 8-step shift.
        run_op(2'b00, 4'd0, 4'b0101, 0, 0, 1, "add before abort");
        ALUop = 2'b10; OPCodeExtension = 4'b0001; ShAmtImm = SHW'(8); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort shift cycle", 32'(observed()),
                  32'(expect_vec(1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, model_cf)));
            if (i < 2) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        model_cf = 1'b0;
        check("abort outputs", 32'(observed()), 32'(zero_vec));
        reset = 1'b0;
        @(negedge clk);
        run_op(2'b01, 4'b0010, 4'd0, 0, 0, -1, "after abort or");

        // Randomized operations.
        for (int k = 0; k < 40; k++) begin
            rop = 2'($urandom_range(0, 3));
            run_op(rop, 4'($urandom), 4'($urandom), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 31)), -1, "random op");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
